// File: rtl/frame_tick_gen.sv
// Multi-channel frame-rate pulse generator: a shared prescaler produces one
// frame_tick per frame, and per-channel dividers pulse ch_enable every div frames.
module frame_tick_gen #(
  parameter int unsigned CYCLES_PER_FRAME = 833333,
  parameter int unsigned CYCLE_W          = 20,
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned DIV_W            = 5,
  parameter int unsigned DEFAULT_DIV      = 15,
  parameter int unsigned FRAME_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_ch,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic               frame_tick,
  output logic [NUM_CH-1:0]  ch_enable,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(CYCLES_PER_FRAME - 1);
  localparam logic [DIV_W-1:0]   RESET_DIV  = DIV_W'(DEFAULT_DIV);

  logic [CYCLE_W-1:0] cycle_cnt;
  logic [CYCLE_W-1:0] cycle_cnt_nxt;
  logic               fe_c;
  logic [FRAME_W-1:0] frame_count_nxt;

  logic [DIV_W-1:0]   div_q    [NUM_CH];
  logic [DIV_W-1:0]   div_nxt  [NUM_CH];
  logic [DIV_W-1:0]   fcnt_q   [NUM_CH];
  logic [DIV_W-1:0]   fcnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  wr_hit;
  logic [NUM_CH-1:0]  ch_term;
  logic [NUM_CH-1:0]  ch_enable_nxt;

  // Frame event: terminal prescaler count while running and not restarting.
  assign fe_c = run && !clear && (cycle_cnt == LAST_CYCLE);

  // Prescaler and frame index next state; clear outranks run.
  always_comb begin
    cycle_cnt_nxt   = cycle_cnt;
    frame_count_nxt = frame_count;
    if (clear) begin
      cycle_cnt_nxt   = '0;
      frame_count_nxt = '0;
    end else if (fe_c) begin
      cycle_cnt_nxt   = '0;
      frame_count_nxt = frame_count + FRAME_W'(1);
    end else if (run) begin
      cycle_cnt_nxt   = cycle_cnt + CYCLE_W'(1);
    end
  end

  // Out-of-range channel indices never match, so such writes are dropped.
  always_comb begin
    wr_hit  = '0;
    ch_term = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = cfg_we && (cfg_ch == 4'(i));
      ch_term[i] = (div_q[i] != '0) && (fcnt_q[i] == (div_q[i] - DIV_W'(1)));
    end
  end

  // Channel dividers: a config write wins over clear and over a same-cycle frame.
  always_comb begin
    ch_enable_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_nxt[i]  = div_q[i];
      fcnt_nxt[i] = fcnt_q[i];
      if (wr_hit[i]) begin
        div_nxt[i]  = cfg_div;
        fcnt_nxt[i] = '0;
      end else if (clear) begin
        fcnt_nxt[i] = '0;
      end else if (fe_c) begin
        if (div_q[i] == '0) begin
          fcnt_nxt[i] = '0;
        end else if (ch_term[i]) begin
          fcnt_nxt[i]      = '0;
          ch_enable_nxt[i] = 1'b1;
        end else begin
          fcnt_nxt[i] = fcnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      frame_count <= '0;
      frame_tick  <= 1'b0;
      ch_enable   <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt_nxt;
      frame_count <= frame_count_nxt;
      frame_tick  <= fe_c;
      ch_enable   <= ch_enable_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= RESET_DIV;
        fcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_nxt[i];
        fcnt_q[i] <= fcnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_frame_tick_gen.sv
// Directed bench for frame_tick_gen: a 4-cycle-frame instance for the main
// scenarios and a 1-cycle-frame, 4-bit-index instance for the wrap corner.
module tb_frame_tick_gen;

  logic        clock = 1'b0;
  logic        reset, run, clear, cfg_we;
  logic [3:0]  cfg_ch;
  logic [4:0]  cfg_div;
  logic        frame_tick;
  logic [3:0]  ch_enable;
  logic [15:0] frame_count;

  logic        f_reset, f_run, f_clear, f_cfg_we;
  logic [3:0]  f_cfg_ch;
  logic [2:0]  f_cfg_div;
  logic        f_frame_tick;
  logic [1:0]  f_ch_enable;
  logic [3:0]  f_frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  frame_tick_gen #(
    .CYCLES_PER_FRAME(4), .CYCLE_W(2), .NUM_CH(4), .DIV_W(5),
    .DEFAULT_DIV(15), .FRAME_W(16)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .clear(clear),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .frame_tick(frame_tick), .ch_enable(ch_enable), .frame_count(frame_count)
  );

  frame_tick_gen #(
    .CYCLES_PER_FRAME(1), .CYCLE_W(1), .NUM_CH(2), .DIV_W(3),
    .DEFAULT_DIV(3), .FRAME_W(4)
  ) u_fast (
    .clock(clock), .reset(f_reset), .run(f_run), .clear(f_clear),
    .cfg_we(f_cfg_we), .cfg_ch(f_cfg_ch), .cfg_div(f_cfg_div),
    .frame_tick(f_frame_tick), .ch_enable(f_ch_enable), .frame_count(f_frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int ft_n, ch_n, bad, c0, c1, c2, c3;

    reset = 1'b0; run = 1'b1; clear = 1'b0;
    cfg_we = 1'b0; cfg_ch = 4'd0; cfg_div = 5'd0;
    f_reset = 1'b0; f_run = 1'b1; f_clear = 1'b0;
    f_cfg_we = 1'b0; f_cfg_ch = 4'd0; f_cfg_div = 3'd0;

    step(2);
    chk("rst_ft", 32'(frame_tick), 0);
    chk("rst_ch", 32'(ch_enable), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_fast_ft", 32'(f_frame_tick), 0);

    // Scenario 1: default divisors, frame_tick every 4 clocks.
    reset = 1'b1;
    step(3);                                         // edge 3
    chk("s1_ft_e3", 32'(frame_tick), 0);
    chk("s1_fc_e3", 32'(frame_count), 0);
    step(1);                                         // edge 4
    chk("s1_ft_e4", 32'(frame_tick), 1);
    chk("s1_fc_e4", 32'(frame_count), 1);
    chk("s1_ch_e4", 32'(ch_enable), 0);
    step(1);                                         // edge 5
    chk("s1_ft_e5", 32'(frame_tick), 0);
    step(54);                                        // edge 59
    chk("s1_fc_e59", 32'(frame_count), 14);
    chk("s1_ch_e59", 32'(ch_enable), 0);
    step(1);                                         // edge 60
    chk("s1_ft_e60", 32'(frame_tick), 1);
    chk("s1_ch_e60", 32'(ch_enable), 32'hF);
    chk("s1_fc_e60", 32'(frame_count), 15);
    ft_n = 0; ch_n = 0;
    for (int k = 0; k < 60; k++) begin               // edges 61..120
      step(1);
      if (frame_tick) ft_n++;
      if (ch_enable != 4'd0) ch_n++;
    end
    chk("s1_ft_count", 32'(ft_n), 15);
    chk("s1_ch_count", 32'(ch_n), 1);
    chk("s1_ch_e120", 32'(ch_enable), 32'hF);
    chk("s1_fc_e120", 32'(frame_count), 30);

    // Scenario 2: per-channel divisors 1, 2, 0; ch3 stays at 15.
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 5'd1; step(1);
    cfg_ch = 4'd1; cfg_div = 5'd2; step(1);
    cfg_ch = 4'd2; cfg_div = 5'd0; step(1);          // edge 123
    cfg_we = 1'b0;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; bad = 0;
    for (int k = 0; k < 60; k++) begin               // edges 124..183
      step(1);
      if (ch_enable[0]) c0++;
      if (ch_enable[1]) c1++;
      if (ch_enable[2]) c2++;
      if (ch_enable[3]) c3++;
      if ((ch_enable != 4'd0) && !frame_tick) bad++;
    end
    chk("s2_ch0_count", 32'(c0), 15);
    chk("s2_ch1_count", 32'(c1), 7);
    chk("s2_ch2_count", 32'(c2), 0);
    chk("s2_ch3_count", 32'(c3), 1);
    chk("s2_ch_without_ft", 32'(bad), 0);

    // Scenario 3: rewrite ch1 in the frame-event cycle; its pulse is suppressed.
    cfg_we = 1'b1; cfg_ch = 4'd1; cfg_div = 5'd2;
    step(1);                                         // edge 184
    cfg_we = 1'b0;
    chk("s3_ft_e184", 32'(frame_tick), 1);
    chk("s3_ch_e184", 32'(ch_enable), 32'h1);
    chk("s3_fc_e184", 32'(frame_count), 46);
    step(4);                                         // edge 188
    chk("s3_ch_e188", 32'(ch_enable), 32'h1);
    step(4);                                         // edge 192
    chk("s3_ch_e192", 32'(ch_enable), 32'h3);
    chk("s3_fc_e192", 32'(frame_count), 48);

    // Scenario 4: pause 10 clocks at cycle_cnt=2, then clear.
    step(2);                                         // edge 194
    run = 1'b0;
    ft_n = 0;
    for (int k = 0; k < 10; k++) begin               // edges 195..204
      step(1);
      if (frame_tick || (ch_enable != 4'd0)) ft_n++;
    end
    run = 1'b1;
    chk("s4_pause_pulses", 32'(ft_n), 0);
    chk("s4_pause_fc", 32'(frame_count), 48);
    step(1);                                         // edge 205
    chk("s4_ft_e205", 32'(frame_tick), 0);
    step(1);                                         // edge 206
    chk("s4_ft_e206", 32'(frame_tick), 1);
    chk("s4_fc_e206", 32'(frame_count), 49);
    chk("s4_ch_e206", 32'(ch_enable), 32'h1);
    step(1);                                         // edge 207
    clear = 1'b1;
    step(1);                                         // edge 208
    clear = 1'b0;
    chk("s4_clr_fc", 32'(frame_count), 0);
    chk("s4_clr_ft", 32'(frame_tick), 0);
    step(3);                                         // edge 211
    chk("s4_ft_e211", 32'(frame_tick), 0);
    step(1);                                         // edge 212
    chk("s4_ft_e212", 32'(frame_tick), 1);
    chk("s4_fc_e212", 32'(frame_count), 1);
    chk("s4_ch_e212", 32'(ch_enable), 32'h1);

    // Scenario 5: async reset at cycle_cnt=3 of frame 14.
    step(55);                                        // edge 267
    chk("s5_fc_pre", 32'(frame_count), 14);
    reset = 1'b0;
    #1;
    chk("s5_fc_async", 32'(frame_count), 0);
    chk("s5_ft_async", 32'(frame_tick), 0);
    chk("s5_ch_async", 32'(ch_enable), 0);
    step(2);

    // Scenario 6: out-of-range write on the first cycle after release.
    reset = 1'b1;
    cfg_we = 1'b1; cfg_ch = 4'd7; cfg_div = 5'd1;
    step(1);                                         // edge 1
    cfg_we = 1'b0;
    chk("s6_fc_e1", 32'(frame_count), 0);
    chk("s6_ft_e1", 32'(frame_tick), 0);
    step(2);                                         // edge 3
    chk("s6_ft_e3", 32'(frame_tick), 0);
    step(1);                                         // edge 4
    chk("s6_ft_e4", 32'(frame_tick), 1);
    chk("s6_ch_e4", 32'(ch_enable), 0);
    chk("s6_fc_e4", 32'(frame_count), 1);
    step(56);                                        // edge 60
    chk("s6_ch_e60", 32'(ch_enable), 32'hF);
    chk("s6_fc_e60", 32'(frame_count), 15);

    // One-cycle frames: frame_tick held high and frame index wraps.
    f_reset = 1'b1;
    step(1);
    chk("fast_ft_e1", 32'(f_frame_tick), 1);
    chk("fast_fc_e1", 32'(f_frame_count), 1);
    step(13);
    chk("fast_fc_e14", 32'(f_frame_count), 14);
    chk("fast_ch_e14", 32'(f_ch_enable), 0);
    step(1);
    chk("fast_fc_e15", 32'(f_frame_count), 15);
    chk("fast_ch_e15", 32'(f_ch_enable), 32'h3);
    step(1);
    chk("fast_fc_wrap", 32'(f_frame_count), 0);
    chk("fast_ft_e16", 32'(f_frame_tick), 1);
    chk("fast_ch_e16", 32'(f_ch_enable), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
